// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the single write port of the general register file. It merges the
//   in-order pipeline writeback stream with results from a long-latency unit
//   (mul/div). Those results are buffered in a small circular FIFO. The
//   pipeline always has priority. The FIFO head is popped only in cycles
//   where the pipeline has no real write. A write to $0 does not count as a
//   real write.
//
//   Optional feature: define WB_FWD_EN to build the output-stage forwarding
//   lookup (q_fwd_valid/q_fwd_data). Without it those ports are tied to 0.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   pipe_we/addr/wd/pc4              pipeline writeback (no backpressure)
//   aux_valid/ready/addr/wd/pc4      aux result handshake into the FIFO
//   grf_we/a3/wd/pc4                 registered register-file write port
//   q_addr, q_hit                    hazard lookup over pending FIFO entries
//   stall_req                        FIFO head starving, bubble the pipe
//   q_fwd_valid, q_fwd_data          output-stage forward lookup
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc4,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_wd,
    input  logic [31:0] aux_pc4,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc4,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic        stall_req,
    output logic        q_fwd_valid,
    output logic [31:0] q_fwd_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);
    localparam logic [3:0]  STARVE_C  = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] pc4;
    } wb_req_t;

    wb_req_t [DEPTH-1:0] fifo_mem;
    logic    [DEPTH-1:0] slot_vld;   // per-slot occupancy, feeds q_hit
    logic    [PW-1:0]    rd_ptr, wr_ptr;
    logic    [PW:0]      count;
    logic    [3:0]       age;

    logic pipe_sel, fifo_empty, push, pop;

    assign pipe_sel   = pipe_we && (pipe_addr != 5'd0);
    assign fifo_empty = (count == '0);
    // Readiness depends only on the current count. A pop at this edge does
    // not free a slot for a push at the same edge.
    assign aux_ready  = (count < FULL_CNT) && !reset;
    // A zero-address result is handshaken but dropped; it never occupies a slot.
    assign push       = aux_valid && aux_ready && (aux_addr != 5'd0);
    assign pop        = !pipe_sel && !fifo_empty;

    // FIFO storage needs no reset; slot_vld and count qualify it.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{addr: aux_addr, wd: aux_wd, pc4: aux_pc4};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (pop) begin
                rd_ptr           <= rd_ptr + PW'(1);
                slot_vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr           <= wr_ptr + PW'(1);
                slot_vld[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head age: counts cycles the oldest entry has waited without a pop.
    always_ff @(posedge clk) begin
        if (reset || pop || fifo_empty)
            age <= '0;
        else if (age != 4'hF)
            age <= age + 1'b1;
    end

    assign stall_req = (age >= STARVE_C);

    // Output stage. When nothing is selected the address and data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we  <= 1'b0;
            grf_a3  <= '0;
            grf_wd  <= '0;
            grf_pc4 <= '0;
        end else if (pipe_sel) begin
            grf_we  <= 1'b1;
            grf_a3  <= pipe_addr;
            grf_wd  <= pipe_wd;
            grf_pc4 <= pipe_pc4;
        end else if (pop) begin
            grf_we  <= 1'b1;
            grf_a3  <= fifo_mem[rd_ptr].addr;
            grf_wd  <= fifo_mem[rd_ptr].wd;
            grf_pc4 <= fifo_mem[rd_ptr].pc4;
        end else begin
            grf_we  <= 1'b0;
        end
    end

    // Pending-write lookup over occupied slots only. The output stage and
    // the in-flight aux input are excluded.
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_vld[i] && (fifo_mem[i].addr == q_addr) && (q_addr != 5'd0))
                q_hit = 1'b1;
    end

`ifdef WB_FWD_EN
    // The output stage holds a write the register file commits at the next
    // edge. This lookup lets decode bypass it.
    assign q_fwd_valid = grf_we && (grf_a3 == q_addr) && (q_addr != 5'd0);
    assign q_fwd_data  = grf_wd;
`else
    assign q_fwd_valid = 1'b0;
    assign q_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_wd, pipe_pc4;
    logic        aux_valid, aux_ready;
    logic [4:0]  aux_addr;
    logic [31:0] aux_wd, aux_pc4;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc4;
    logic [4:0]  q_addr;
    logic        q_hit, stall_req, q_fwd_valid;
    logic [31:0] q_fwd_data;

    int n_chk  = 0;
    int n_fail = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wd(pipe_wd), .pipe_pc4(pipe_pc4),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
        .aux_wd(aux_wd), .aux_pc4(aux_pc4),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc4(grf_pc4),
        .q_addr(q_addr), .q_hit(q_hit), .stall_req(stall_req),
        .q_fwd_valid(q_fwd_valid), .q_fwd_data(q_fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, pwe;
        logic [4:0] pa;
        logic       av;
        logic [4:0] aa, qa;
        logic       e_we;
        logic [4:0] e_a3;
        logic       e_rdy, e_hit, e_stall;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    vec_t vt[24];

    function automatic vec_t mk(logic rst, logic pwe, logic [4:0] pa, logic av,
                                logic [4:0] aa, logic [4:0] qa, logic e_we,
                                logic [4:0] e_a3, logic e_rdy, logic e_hit, logic e_stall);
        vec_t v;
        v.rst = rst; v.pwe = pwe; v.pa = pa; v.av = av; v.aa = aa; v.qa = qa;
        v.e_we = e_we; v.e_a3 = e_a3; v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_addr = 0; pipe_wd = 0; pipe_pc4 = 0;
        aux_valid = 0; aux_addr = 0; aux_wd = 0; aux_pc4 = 0;
    endtask

    ent_t mq[$];
    ent_t sb[$];
    int   age_m;

    initial begin
        // Directed vectors for DEPTH=2, STARVE_LIMIT=4.
        // Columns: rst pwe pa av aa qa | we a3 rdy hit stall (after the edge)
        vt[0]  = mk(0,1, 5,0, 0, 0, 1, 5,1,0,0);
        vt[1]  = mk(0,0, 0,0, 0, 0, 0, 5,1,0,0);
        vt[2]  = mk(0,0, 0,1, 8, 8, 0, 5,1,1,0);
        vt[3]  = mk(0,0, 0,0, 0, 8, 1, 8,1,0,0);
        vt[4]  = mk(0,0, 0,0, 0, 8, 0, 8,1,0,0);
        vt[5]  = mk(0,1, 3,1, 1, 1, 1, 3,1,1,0);
        vt[6]  = mk(0,1, 3,1, 2, 2, 1, 3,0,1,0);
        vt[7]  = mk(0,1, 3,0, 0, 1, 1, 3,0,1,0);
        vt[8]  = mk(0,1, 3,0, 0, 1, 1, 3,0,1,0);
        vt[9]  = mk(0,1, 3,0, 0, 1, 1, 3,0,1,1);
        vt[10] = mk(0,1, 3,0, 0, 2, 1, 3,0,1,1);
        vt[11] = mk(0,0, 0,0, 0, 1, 1, 1,1,0,0);
        vt[12] = mk(0,0, 0,0, 0, 2, 1, 2,1,0,0);
        vt[13] = mk(0,0, 0,0, 0, 2, 0, 2,1,0,0);
        vt[14] = mk(0,0, 0,1, 9, 9, 0, 2,1,1,0);
        vt[15] = mk(0,1, 0,1, 0, 9, 1, 9,1,0,0);
        vt[16] = mk(0,0, 0,0, 0, 9, 0, 9,1,0,0);
        vt[17] = mk(0,0, 0,1, 4, 4, 0, 9,1,1,0);
        vt[18] = mk(0,0, 0,1, 6, 6, 1, 4,1,1,0);
        vt[19] = mk(0,0, 0,0, 0, 6, 1, 6,1,0,0);
        vt[20] = mk(0,1, 3,1,10,10, 1, 3,1,1,0);
        vt[21] = mk(0,1, 3,1,11,11, 1, 3,0,1,0);
        vt[22] = mk(1,1, 3,0, 0,10, 0, 0,0,0,0);
        vt[23] = mk(0,0, 0,0, 0,10, 0, 0,1,0,0);

        // Reset state
        idle_inputs(); q_addr = 0; reset = 1;
        tick(); tick();
        chk("rst_we", grf_we, 0);
        chk("rst_a3", grf_a3, 0);
        chk("rst_wd", grf_wd, 0);
        chk("rst_pc4", grf_pc4, 0);
        chk("rst_ready", aux_ready, 0);
        chk("rst_hit", q_hit, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_fwd_v", q_fwd_valid, 0);
        chk("rst_fwd_d", q_fwd_data, 0);
        reset = 0;
        #1 chk("rel_ready", aux_ready, 1);

        // Pipe write: one cycle latency, then idle
        pipe_we = 1; pipe_addr = 5; pipe_wd = 32'h1234; pipe_pc4 = 32'h3004;
        tick();
        idle_inputs();
        chk("pipe_we", grf_we, 1);
        chk("pipe_a3", grf_a3, 5);
        chk("pipe_wd", grf_wd, 32'h1234);
        chk("pipe_pc4", grf_pc4, 32'h3004);
        tick();
        chk("pipe_we_off", grf_we, 0);
        chk("pipe_hold_wd", grf_wd, 32'h1234);

        // Output-stage forwarding
        pipe_we = 1; pipe_addr = 7; pipe_wd = 32'h55; pipe_pc4 = 32'h4000; q_addr = 7;
        tick();
        idle_inputs();
`ifdef WB_FWD_EN
        chk("fwd_valid", q_fwd_valid, 1);
        chk("fwd_data", q_fwd_data, 32'h55);
`else
        chk("fwd_valid", q_fwd_valid, 0);
        chk("fwd_data", q_fwd_data, 0);
`endif
        tick();
        chk("fwd_valid_off", q_fwd_valid, 0);

        // Aux data path check: push addr 8, observe data two cycles later
        aux_valid = 1; aux_addr = 8; aux_wd = 32'hAA; aux_pc4 = 32'h5008; q_addr = 8;
        tick();
        idle_inputs();
        chk("aux_hit", q_hit, 1);
        chk("aux_we_early", grf_we, 0);
        tick();
        chk("aux_we", grf_we, 1);
        chk("aux_wd", grf_wd, 32'hAA);
        chk("aux_pc4", grf_pc4, 32'h5008);
        chk("aux_hit_off", q_hit, 0);
        tick();

        // Directed table
        for (int i = 0; i < 24; i++) begin
            reset = vt[i].rst; pipe_we = vt[i].pwe; pipe_addr = vt[i].pa;
            pipe_wd = 32'h1000 | 32'(vt[i].pa); pipe_pc4 = 32'h3000 + 32'(vt[i].pa);
            aux_valid = vt[i].av; aux_addr = vt[i].aa;
            aux_wd = 32'h2000 | 32'(vt[i].aa); aux_pc4 = 32'h6000 + 32'(vt[i].aa);
            q_addr = vt[i].qa;
            tick();
            chk($sformatf("v%0d_we", i), grf_we, vt[i].e_we);
            chk($sformatf("v%0d_a3", i), grf_a3, vt[i].e_a3);
            chk($sformatf("v%0d_rdy", i), aux_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_hit", i), q_hit, vt[i].e_hit);
            chk($sformatf("v%0d_stall", i), stall_req, vt[i].e_stall);
        end

        // Random traffic against a queue model with a write scoreboard
        idle_inputs(); reset = 1; tick(); reset = 0;
        mq.delete(); sb.delete(); age_m = 0;
        for (int c = 0; c < 600; c++) begin
            logic psel, pop_m, m_hit;
            int   sz0;
            ent_t e;
            sz0 = mq.size();
            pipe_we   = (age_m >= STARVE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) < 4);
            pipe_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_wd   = $urandom; pipe_pc4 = $urandom;
            aux_valid = ($urandom_range(0, 2) != 0);
            aux_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            aux_wd    = $urandom; aux_pc4 = $urandom;
            if (sz0 != 0 && $urandom_range(0, 1) == 1)
                q_addr = mq[$urandom_range(0, sz0 - 1)].a;
            else
                q_addr = 5'($urandom_range(0, 31));
            #1;
            m_hit = 0;
            foreach (mq[k]) if (mq[k].a == q_addr && q_addr != 0) m_hit = 1;
            chk("rnd_ready", aux_ready, (sz0 < DEPTH));
            chk("rnd_hit", q_hit, m_hit);
            chk("rnd_stall", stall_req, (age_m >= STARVE));

            psel  = pipe_we && pipe_addr != 0;
            pop_m = !psel && sz0 != 0;
            if (psel) begin
                e.a = pipe_addr; e.d = pipe_wd; e.p = pipe_pc4;
                sb.push_back(e);
            end else if (pop_m) begin
                sb.push_back(mq.pop_front());
            end
            if (aux_valid && sz0 < DEPTH && aux_addr != 0) begin
                e.a = aux_addr; e.d = aux_wd; e.p = aux_pc4;
                mq.push_back(e);
            end
            if (pop_m || sz0 == 0) age_m = 0;
            else if (age_m < 15) age_m++;

            @(posedge clk); #1;
            if (grf_we) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious_we", grf_we, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_a3", grf_a3, e.a);
                    chk("rnd_wd", grf_wd, e.d);
                    chk("rnd_pc4", grf_pc4, e.p);
                end
            end else if (sb.size() != 0) begin
                chk("rnd_missing_we", grf_we, 1);
                void'(sb.pop_front());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
